uart_axi_arbiter: RTL



---
 rtl/uart_axi_arbiter_if.sv | 47 ++++
 rtl/uart_axi_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_axi_arbiter_if.sv
// AXI4-lite bus between uart_axi_arbiter (master) and the UART-Lite slave.
// Ports: AR/R read channels, AW/W/B write channels; master and slave modports.
interface uart_axi_arbiter_if;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uart_axi_arbiter.sv
// Shares one UART-Lite AXI4-lite port between a byte RX client and a word TX client.
// Ports: clk, rstn, rx_req/rx_ack/rx_data, tx_valid/tx_ready/tx_word/tx_done, err, uart_axi (master).
// Status polling is hidden: RX waits for STAT bit0, TX waits for STAT bit3 clear, 4 bytes LSB first.
// Optional macro UART_AXI_ARBITER_RESP_CHECK_EN: sticky err on nonzero rresp/bresp.
module uart_axi_arbiter #(
  parameter int unsigned POLL_GAP  = 4,
  parameter logic [3:0]  STAT_ADDR = 4'h8,
  parameter logic [3:0]  RX_ADDR   = 4'h0,
  parameter logic [3:0]  TX_ADDR   = 4'h4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_req,
  output logic        rx_ack,
  output logic [7:0]  rx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_word,
  output logic        tx_done,
  output logic        err,
  uart_axi_arbiter_if.master uart_axi
);

  typedef enum logic [2:0] {
    IDLE, ST_AR, ST_R, D_AR, D_R, TX_AW, TX_B, GAP
  } state_t;

  localparam logic G_RX = 1'b0;
  localparam logic G_TX = 1'b1;
  localparam logic [15:0] GAP_LAST =
    (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

  state_t      state, state_nx;
  logic        last_grant;
  logic        pend;
  logic        aw_ok, w_ok;
  logic [1:0]  idx;
  logic [31:0] word;
  logic [7:0]  wbyte;
  logic [15:0] gap_cnt;

  logic rx_want, gnt, gnt_tx;
  logic aw_fin, w_fin, stat_ok;

  // rx_req is still high in the ack cycle; masking it avoids a second read.
  always_comb begin
    rx_want = rx_req & ~rx_ack;
    gnt     = rx_want | pend;
    gnt_tx  = pend & (~rx_want | (last_grant == G_RX));
    aw_fin  = aw_ok | uart_axi.awready;
    w_fin   = w_ok | uart_axi.wready;
    stat_ok = (last_grant == G_RX) ? uart_axi.rdata[0]
                                   : ~uart_axi.rdata[3];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt) state_nx = ST_AR;
      ST_AR: if (uart_axi.arready) state_nx = ST_R;
      ST_R:
        if (uart_axi.rvalid) begin
          if (!stat_ok)                state_nx = GAP;
          else if (last_grant == G_RX) state_nx = D_AR;
          else                         state_nx = TX_AW;
        end
      D_AR:  if (uart_axi.arready) state_nx = D_R;
      D_R:   if (uart_axi.rvalid) state_nx = IDLE;
      TX_AW: if (aw_fin && w_fin) state_nx = TX_B;
      TX_B:  if (uart_axi.bvalid) state_nx = IDLE;
      GAP:   if (gap_cnt == GAP_LAST) state_nx = IDLE;
    endcase
  end

  always_comb begin
    uart_axi.arvalid = (state == ST_AR) || (state == D_AR);
    uart_axi.araddr  = ((state == D_AR) || (state == D_R))
                       ? RX_ADDR : STAT_ADDR;
    uart_axi.rready  = (state == ST_R) || (state == D_R);
    uart_axi.awvalid = (state == TX_AW) && !aw_ok;
    uart_axi.wvalid  = (state == TX_AW) && !w_ok;
    uart_axi.awaddr  = ((state == TX_AW) || (state == TX_B))
                       ? TX_ADDR : STAT_ADDR;
    uart_axi.wdata   = {24'b0, wbyte};
    uart_axi.wstrb   = 4'h1;
    uart_axi.bready  = (state == TX_B);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= G_TX;
      pend       <= 1'b0;
      aw_ok      <= 1'b0;
      w_ok       <= 1'b0;
      idx        <= 2'd0;
      word       <= 32'd0;
      wbyte      <= 8'd0;
      gap_cnt    <= 16'd0;
      rx_ack     <= 1'b0;
      rx_data    <= 8'd0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      rx_ack  <= 1'b0;
      tx_done <= 1'b0;
      if (tx_valid && tx_ready) begin
        word     <= tx_word;
        pend     <= 1'b1;
        tx_ready <= 1'b0;
      end
      if (state == IDLE && gnt)
        last_grant <= gnt_tx ? G_TX : G_RX;
      if (state == ST_R && uart_axi.rvalid && stat_ok &&
          last_grant == G_TX)
        wbyte <= word[{idx, 3'b000} +: 8];
      if (state == TX_AW) begin
        if (aw_fin && w_fin) begin
          aw_ok <= 1'b0;
          w_ok  <= 1'b0;
        end else begin
          if (uart_axi.awready) aw_ok <= 1'b1;
          if (uart_axi.wready)  w_ok  <= 1'b1;
        end
      end
      if (state == D_R && uart_axi.rvalid) begin
        rx_data <= uart_axi.rdata[7:0];
        rx_ack  <= 1'b1;
      end
      if (state == TX_B && uart_axi.bvalid) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          pend     <= 1'b0;
          tx_done  <= 1'b1;
          tx_ready <= 1'b1;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

`ifdef UART_AXI_ARBITER_RESP_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err <= 1'b0;
    else if ((uart_axi.rready && uart_axi.rvalid &&
              uart_axi.rresp != 2'b00) ||
             (uart_axi.bready && uart_axi.bvalid &&
              uart_axi.bresp != 2'b00))
      err <= 1'b1;
  end
  logic unused_bits;
  assign unused_bits = &{1'b0, uart_axi.rdata[31:8]};
`else
  assign err = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, uart_axi.rdata[31:8],
                         uart_axi.rresp, uart_axi.bresp};
`endif

endmodule
